// File: rtl/sensor_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : checkers_sensor_pkg
// Purpose  : Shared geometry constants and scanner state encoding for the
//            checkerboard reed-switch scanner.
// Revision : 1.0 - initial release
// ============================================================================
package checkers_sensor_pkg;

    localparam int NUM_ROWS     = 8;
    localparam int COLS_PER_ROW = 4;
    localparam int NUM_SQUARES  = NUM_ROWS * COLS_PER_ROW;

    // Scanner sequencer states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_COMMIT = 2'd3
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/sensor_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : sensor_scanner_if
// Purpose  : Bundles the scanner's enable, matrix sense/strobe lines and the
//            published occupancy outputs. The slave modport is the scanner,
//            the master modport is the board/host side.
// Revision : 1.0 - initial release
// ============================================================================
interface sensor_scanner_if;

    logic                                        scan_en;
    logic [checkers_sensor_pkg::COLS_PER_ROW-1:0] col_in;
    logic [checkers_sensor_pkg::NUM_ROWS-1:0]     row_drive;
    logic [checkers_sensor_pkg::NUM_SQUARES-1:0]  sensor_board;
    logic                                        board_changed;
    logic                                        scan_done;

    modport master (
        output scan_en,
        output col_in,
        input  row_drive,
        input  sensor_board,
        input  board_changed,
        input  scan_done
    );

    modport slave (
        input  scan_en,
        input  col_in,
        output row_drive,
        output sensor_board,
        output board_changed,
        output scan_done
    );

endinterface
`default_nettype wire

// File: rtl/sensor_scanner_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Purpose  : Publishes a captured frame as the occupancy word. With
//            SENSOR_DEBOUNCE_EN defined, a frame must repeat DEBOUNCE_SCANS
//            consecutive times before it is published; otherwise every frame
//            that differs from the current word is published immediately.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_debounce
    import checkers_sensor_pkg::*;
`ifdef SENSOR_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_SCANS = 4
)
`endif
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   commit,
    input  logic [NUM_SQUARES-1:0] raw,
    output logic [NUM_SQUARES-1:0] sensor_board,
    output logic                   board_changed
);

    logic [NUM_SQUARES-1:0] r_board;
    logic                   r_changed;
    logic                   w_publish;

`ifdef SENSOR_DEBOUNCE_EN
    localparam int c_CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_SCANS - 1);

    logic [NUM_SQUARES-1:0] r_prev_raw;
    logic [c_CNT_W-1:0]     r_stable_cnt;
    logic [c_CNT_W-1:0]     w_cnt_next;

    // Saturating run length of identical frames and the publish decision.
    always_comb begin
        w_cnt_next = '0;
        if (raw == r_prev_raw) begin
            w_cnt_next = (r_stable_cnt == c_CNT_MAX) ? c_CNT_MAX : r_stable_cnt + 1'b1;
        end
        w_publish = commit && (w_cnt_next == c_CNT_MAX) && (raw != r_board);
    end

    // Frame history, advanced once per completed frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_raw   <= '0;
            r_stable_cnt <= '0;
        end else if (commit) begin
            r_prev_raw   <= raw;
            r_stable_cnt <= w_cnt_next;
        end
    end
`else
    // Without history, any frame that differs from the current word is published.
    always_comb begin
        w_publish = commit && (raw != r_board);
    end
`endif

    // Published word and its one-cycle change strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_board   <= '0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_publish;
            if (w_publish) begin
                r_board <= raw;
            end
        end
    end

    assign sensor_board  = r_board;
    assign board_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/sensor_scanner.sv
`default_nettype none
// ============================================================================
// Module   : sensor_scanner
// Purpose  : Row-by-row scanner for the 8x4 reed-switch matrix. Drives one
//            row at a time, lets it settle, samples the synchronized columns
//            and hands each complete frame to sensor_debounce.
//            Optional feature macro: SENSOR_DEBOUNCE_EN (multi-frame debounce).
// Revision : 1.0 - initial release
// ============================================================================
module sensor_scanner
    import checkers_sensor_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            clock,
    input  logic            reset,
    sensor_scanner_if.slave bus
);

    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam int c_ROW_W = $clog2(NUM_ROWS);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(NUM_ROWS - 1);
    localparam int c_COL_SH = $clog2(COLS_PER_ROW);

    // Reject configurations the timing does not support.
    generate
        if (SETTLE_CYCLES < 3) begin : g_settle_range
            $error("sensor_scanner: SETTLE_CYCLES must be at least 3");
        end
        if (DEBOUNCE_SCANS < 1) begin : g_debounce_range
            $error("sensor_scanner: DEBOUNCE_SCANS must be at least 1");
        end
    endgenerate

    scan_state_t                  r_state;
    scan_state_t                  w_state_next;
    logic [c_SETTLE_W-1:0]        r_settle_cnt;
    logic [c_ROW_W-1:0]           r_row;
    logic [NUM_SQUARES-1:0]       r_raw;
    logic [COLS_PER_ROW-1:0]      r_col_meta;
    logic [COLS_PER_ROW-1:0]      r_col_sync;
    logic                         r_scan_done;
    logic [NUM_ROWS-1:0]          w_row_drive;
    logic [$clog2(NUM_SQUARES)-1:0] w_raw_base;
    logic                         w_commit;

    assign w_raw_base = {r_row, c_COL_SH'(0)};
    assign w_commit   = (r_state == ST_COMMIT);

    // Two-flop synchronizer for the asynchronous column sense lines.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_col_meta <= '0;
            r_col_sync <= '0;
        end else begin
            r_col_meta <= bus.col_in;
            r_col_sync <= r_col_meta;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and row strobe; a frame always runs to COMMIT once started.
    always_comb begin
        w_state_next = r_state;
        w_row_drive  = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.scan_en) begin
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_row_drive[r_row] = 1'b1;
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_row_drive[r_row] = 1'b1;
                w_state_next = (r_row == c_LAST_ROW) ? ST_COMMIT : ST_DRIVE;
            end
            ST_COMMIT: begin
                w_state_next = bus.scan_en ? ST_DRIVE : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Settle counter, row index and frame capture buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_settle_cnt <= '0;
            r_row        <= '0;
            r_raw        <= '0;
        end else begin
            case (r_state)
                ST_DRIVE: begin
                    // Cleared on the way out so every DRIVE entry starts at zero.
                    r_settle_cnt <= (r_settle_cnt == c_SETTLE_LAST) ? '0 : r_settle_cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    r_raw[w_raw_base +: COLS_PER_ROW] <= r_col_sync;
                    if (r_row != c_LAST_ROW) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_row <= '0;
                end
                default: begin
                    r_settle_cnt <= '0;
                end
            endcase
        end
    end

    // End-of-frame strobe, aligned with the publish outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= w_commit;
        end
    end

    sensor_debounce
`ifdef SENSOR_DEBOUNCE_EN
    #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    )
`endif
    u_debounce (
        .clock         (clock),
        .reset         (reset),
        .commit        (w_commit),
        .raw           (r_raw),
        .sensor_board  (bus.sensor_board),
        .board_changed (bus.board_changed)
    );

    assign bus.row_drive = w_row_drive;
    assign bus.scan_done = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_sensor_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_scanner
// Purpose  : Directed self-checking bench for sensor_scanner. A small board
//            model answers each driven row with that row's columns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_scanner;
    import checkers_sensor_pkg::*;

    localparam int SETTLE = 16;
    localparam int ROW_LEN = SETTLE + 1;
    localparam int FRAME = 8 * ROW_LEN + 1;
`ifdef SENSOR_DEBOUNCE_EN
    localparam int PUB = 4;
`else
    localparam int PUB = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tb_board;
    logic [7:0]  r_mask;
    int n_total = 0;
    int n_bad   = 0;
    int n_chg   = 0;
    int n_done  = 0;

    logic [31:0] b_in  [10] = '{32'h100, 32'h0, 32'h100, 32'h0, 32'h100,
                                32'h0, 32'h100, 32'h100, 32'h100, 32'h100};
`ifdef SENSOR_DEBOUNCE_EN
    logic [31:0] b_exp [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h100};
    logic        c_exp [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    logic [31:0] b_exp [10] = '{32'h100, 32'h0, 32'h100, 32'h0, 32'h100,
                                32'h0, 32'h100, 32'h100, 32'h100, 32'h100};
    logic        c_exp [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

    sensor_scanner_if bus();

    sensor_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] col_of(input logic [31:0] b, input int r);
        logic [31:0] s;
        s = b >> (4 * r);
        return s[3:0];
    endfunction

    // Board model: the driven row returns its columns.
    always_comb begin
        bus.col_in = 4'h0;
        r_mask     = bus.row_drive;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (r_mask[0]) bus.col_in = col_of(tb_board, r);
            r_mask = r_mask >> 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.board_changed === 1'b1) n_chg++;
        if (bus.scan_done === 1'b1) n_done++;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (bus.scan_done !== 1'b1 && k < 2 * FRAME);
        check({tag, " scan_done"}, 32'(bus.scan_done), 32'd1);
    endtask

    task automatic wait_row(input logic [7:0] row, input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (bus.row_drive !== row && k < 2 * FRAME);
        check({tag, " row reached"}, 32'(bus.row_drive), 32'(row));
    endtask

    task automatic do_reset(input logic en);
        bus.scan_en = en;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int row_err;
        int done_err;
        int per;
        int exp_rd;

        tb_board    = 32'h0;
        bus.scan_en = 1'b0;
        rst         = 1'b1;
        do_reset(1'b0);

        // Reset state
        check("rst row_drive", 32'(bus.row_drive), 32'h0);
        check("rst sensor_board", bus.sensor_board, 32'h0);
        check("rst board_changed", 32'(bus.board_changed), 32'h0);
        check("rst scan_done", 32'(bus.scan_done), 32'h0);
        tick();
        check("idle row_drive", 32'(bus.row_drive), 32'h0);

        // Empty board: row stepping, frame length, no publish
        n_chg = 0;
        bus.scan_en = 1'b1;
        row_err  = 0;
        done_err = 0;
        for (int k = 0; k <= FRAME; k++) begin
            tick();
            if (k < FRAME - 1) exp_rd = 1 << (k / ROW_LEN);
            else if (k == FRAME - 1) exp_rd = 0;
            else exp_rd = 1;
            if (32'(bus.row_drive) != 32'(exp_rd)) row_err++;
            if (bus.scan_done !== (k == FRAME)) done_err++;
        end
        check("empty row_drive sequence errors", 32'(row_err), 32'd0);
        check("empty scan_done position errors", 32'(done_err), 32'd0);
        per = 0;
        do begin
            tick();
            per++;
        end while (bus.scan_done !== 1'b1 && per < 2 * FRAME);
        check("empty frame period", 32'(per), 32'(FRAME));
        repeat (3) wait_done("empty");
        check("empty sensor_board", bus.sensor_board, 32'h0);
        check("empty change pulses", 32'(n_chg), 32'd0);

        // Static board
        tb_board = 32'h5000000F;
        do_reset(1'b1);
        n_chg = 0;
        for (int f = 1; f <= 6; f++) begin
            wait_done("static");
            check($sformatf("static f%0d board", f), bus.sensor_board,
                  (f >= PUB) ? 32'h5000000F : 32'h0);
            check($sformatf("static f%0d changed", f), 32'(bus.board_changed),
                  32'(f == PUB));
        end
        check("static change pulses", 32'(n_chg), 32'd1);

        // Bounce on row 2, then hold
        tb_board = b_in[0];
        do_reset(1'b1);
        for (int f = 0; f < 10; f++) begin
            wait_done("bounce");
            check($sformatf("bounce f%0d board", f), bus.sensor_board, b_exp[f]);
            check($sformatf("bounce f%0d changed", f), 32'(bus.board_changed), 32'(c_exp[f]));
            if (f < 9) tb_board = b_in[f + 1];
        end

        // Mid-frame disable
        wait_row(8'h08, "disable");
        bus.scan_en = 1'b0;
        wait_done("disable");
        check("disable idle row_drive", 32'(bus.row_drive), 32'h0);
        repeat (5) tick();
        check("disable held row_drive", 32'(bus.row_drive), 32'h0);
        check("disable no scan_done", 32'(bus.scan_done), 32'h0);
        bus.scan_en = 1'b1;
        tick();
        check("reenable row_drive", 32'(bus.row_drive), 32'h01);

        // Reset mid-frame with a published board
        tb_board = 32'h5000000F;
        do_reset(1'b1);
        repeat (PUB) wait_done("prereset");
        check("prereset board", bus.sensor_board, 32'h5000000F);
        wait_row(8'h20, "midreset");
        rst = 1'b1;
        tick();
        check("midreset row_drive", 32'(bus.row_drive), 32'h0);
        check("midreset sensor_board", bus.sensor_board, 32'h0);
        check("midreset board_changed", 32'(bus.board_changed), 32'h0);
        check("midreset scan_done", 32'(bus.scan_done), 32'h0);
        rst = 1'b0;
        for (int f = 1; f <= PUB; f++) begin
            wait_done("postreset");
            check($sformatf("postreset f%0d board", f), bus.sensor_board,
                  (f == PUB) ? 32'h5000000F : 32'h0);
            check($sformatf("postreset f%0d changed", f), 32'(bus.board_changed),
                  32'(f == PUB));
        end

        // Board change 0 -> 0x000000F0
        tb_board = 32'h0;
        do_reset(1'b1);
        repeat (2) wait_done("pre-change");
        check("pre-change board", bus.sensor_board, 32'h0);
        tb_board = 32'h000000F0;
        for (int f = 1; f <= PUB + 1; f++) begin
            wait_done("change");
            check($sformatf("change f%0d board", f), bus.sensor_board,
                  (f >= PUB) ? 32'h000000F0 : 32'h0);
            check($sformatf("change f%0d changed", f), 32'(bus.board_changed),
                  32'(f == PUB));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_scanner.md
# sensor_scanner

Scans the checkerboard's reed-switch matrix (8 rows × 4 dark squares per row) and produces a debounced 32-bit occupancy word. The word feeds the memory manager's `sensorBoardIn`, which the CPU reads at address 0x1000. A full frame is captured row by row. A new board is published only after it has matched for a configurable number of consecutive frames.

## Interface
- `SETTLE_CYCLES`, default 16: cycles a row is driven before its columns are sampled; must be ≥ 3.
- `DEBOUNCE_SCANS`, default 4: consecutive identical frames required before publishing; must be ≥ 1.
- `clock`, input, 1: single system clock.
- `reset`, input, 1: synchronous, active-high.
- `scan_en`, input, 1: enables continuous scanning.
- `col_in`, input, 4: column sense lines, asynchronous; 1 means piece present.
- `row_drive`, output, 8: one-hot row strobe; bit r drives row r.
- `sensor_board`, output, 32: debounced occupancy; bit r*4+c is row r, column c.
- `board_changed`, output, 1: one-cycle pulse when `sensor_board` updates.
- `scan_done`, output, 1: one-cycle pulse at the end of every frame.

## Operation
- `col_in` passes through a 2-flop synchronizer before use.
- States:
  - IDLE: `row_drive` = 0. Goes to DRIVE (row 0) when `scan_en` = 1.
  - DRIVE: `row_drive` = 1<<row. A settle counter runs SETTLE_CYCLES cycles, then the block goes to SAMPLE.
  - SAMPLE: `row_drive` is held for 1 cycle. The synchronized `col_in` is latched into `raw[row*4 +: 4]`.
    - If row < 7: row increments and the block goes to DRIVE.
    - If row = 7: the block goes to COMMIT.
  - COMMIT: `row_drive` = 0 for 1 cycle and `scan_done` pulses. Row resets to 0. Next state is DRIVE if `scan_en` = 1, else IDLE.
- Deasserting `scan_en` mid-frame does not abort the frame. The frame completes, then the block idles.
- Debounce, evaluated in COMMIT:
  - If `raw` == `prev_raw`: `stable_cnt` = min(`stable_cnt` + 1, DEBOUNCE_SCANS − 1). Otherwise `stable_cnt` = 0.
  - `prev_raw` <= `raw`.
  - If the updated `stable_cnt` == DEBOUNCE_SCANS − 1 and `raw` != `sensor_board`: `sensor_board` <= `raw` and `board_changed` pulses.
  - A republish of an identical value does not pulse `board_changed`.
- DEBOUNCE_SCANS = 1 publishes every differing frame.
- Reset values:
  - Outputs: `row_drive`, `sensor_board`, `board_changed`, `scan_done` all 0.
  - Internal: state IDLE; `raw`, `prev_raw`, counters and row index all 0.
- Reset mid-frame discards the partial frame and clears the debounce history.

## Timing
- Frame length is 8·(SETTLE_CYCLES+1)+1 cycles, which is 137 at the defaults.
- DRIVE for row 0 starts the cycle after `scan_en` is sampled high in IDLE.
- The synchronizer adds 2 cycles of latency. SETTLE_CYCLES ≥ 3 guarantees that the sampled value reflects the driven row.
- `sensor_board` and `board_changed` update on the clock edge that ends COMMIT, in the same cycle as `scan_done`.
- From reset, with a constant non-empty board, the first publish occurs at the DEBOUNCE_SCANS-th `scan_done`.
- A constant empty board never pulses `board_changed`.

## Configuration
- `SENSOR_DEBOUNCE_EN`:
  - Defined: debounce logic as described above.
  - Undefined: `prev_raw` and `stable_cnt` are removed and DEBOUNCE_SCANS is ignored. At every COMMIT, `sensor_board` <= `raw`, and `board_changed` pulses if the value differs.

## Structure
- Package `checkers_sensor_pkg` holds:
  - NUM_ROWS = 8, COLS_PER_ROW = 4, NUM_SQUARES = 32.
  - The scanner state enum (IDLE, DRIVE, SAMPLE, COMMIT).
- Sub-module `sensor_debounce` holds:
  - `prev_raw`, `stable_cnt`, the comparison and the publish register.
  - Inputs: `raw` and a commit strobe. Outputs: `sensor_board` and `board_changed`.
- The top level holds the FSM, the settle counter, the row index and the synchronizer.

## Test plan
- Empty board: reset, `scan_en` = 1, `col_in` = 0.
  - Expect `row_drive` to step 0x01→0x80, each row held 17 cycles.
  - Expect `scan_done` every 137 cycles, `sensor_board` = 0, and no `board_changed`.
- Static board: `col_in` = 4'hF while `row_drive` = 0x01, and 4'h5 while `row_drive` = 0x80; otherwise 0.
  - Expect `sensor_board` = 0x5000000F and a single `board_changed` at the 4th `scan_done`.
  - No further pulses.
- Bounce: alternate frames between 0x1 and 0x0 on row 2.
  - Expect no publish.
  - Then hold 0x1: expect `sensor_board` = 0x00000100 after 4 matching frames, counted from the first 0x1 frame.
- Mid-frame disable: drop `scan_en` while row 3 is driven.
  - Expect the frame to finish, `scan_done` to pulse, then IDLE with `row_drive` = 0.
  - Reassert: expect DRIVE on row 0 the next cycle.
- Reset mid-frame: assert `reset` at row 5 with a published board of 0x5000000F.
  - Expect every output to be 0 the next cycle.
  - Expect the debounce to restart from zero.
- Macro undefined: change the board from 0 to 0x000000F0.
  - Expect publish and `board_changed` at the first following `scan_done`.
